// File: rtl/pcs_10g_scrambler_pair_pkg.sv
// rtl/pcs_10g_scrambler_pair_pkg.sv - shared constants and types for the 10GBASE-R scrambler pair
package pcs_10g_pkg;

  localparam int BLOCK_W   = 66;
  localparam int PAYLOAD_W = 64;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  localparam int STATE_W   = SCR_TAP_B;

  localparam logic [STATE_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef logic [BLOCK_W-1:0]   block_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;
  typedef logic [STATE_W-1:0]   scr_state_t;

  typedef enum logic {
    SCR_MODE_DESCRAMBLE = 1'b0,
    SCR_MODE_SCRAMBLE   = 1'b1
  } scr_mode_e;

endpackage

// File: rtl/pcs_10g_scrambler_pair_if.sv
// rtl/pcs_10g_scrambler_pair_if.sv - 66-bit block stream (header + payload) with valid qualifier
interface pcs_10g_scrambler_pair_if;
  import pcs_10g_pkg::*;

  block_t tdata;
  logic   tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);

endinterface

// File: rtl/pcs_10g_scrambler_pair_core.sv
// rtl/pcs_10g_scrambler_pair_core.sv - combinational 64-bit step of the 1 + x^39 + x^58 LFSR
module pcs_10g_scr_core
  import pcs_10g_pkg::*;
(
  input  scr_state_t state_i,
  input  payload_t   data_i,
  input  scr_mode_e  mode_i,
  output payload_t   data_o,
  output scr_state_t state_o
);

  // hist[h]: oldest scrambled bit at h=0; h>=STATE_W holds bit (h-STATE_W) of this block
  logic [STATE_W+PAYLOAD_W-1:0] hist;

  always_comb begin
    hist   = '0;
    data_o = '0;
    for (int h = 0; h < STATE_W; h++) begin
      hist[h] = state_i[STATE_W-1-h];
    end
    for (int i = 0; i < PAYLOAD_W; i++) begin
      data_o[i] = data_i[i] ^ hist[i+STATE_W-SCR_TAP_A] ^ hist[i+STATE_W-SCR_TAP_B];
      hist[i+STATE_W] = (mode_i == SCR_MODE_SCRAMBLE) ? data_o[i] : data_i[i];
    end
  end

  always_comb begin
    state_o = '0;
    for (int k = 0; k < STATE_W; k++) begin
      state_o[k] = hist[STATE_W+PAYLOAD_W-1-k];
    end
  end

endmodule

// File: rtl/pcs_10g_scrambler_pair_scr.sv
// rtl/pcs_10g_scrambler_pair_scr.sv - registered TX scrambler and RX descrambler around the shared core
module pcs_10g_scrambler
  import pcs_10g_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  block_t tx_block_in,
  input  logic   tx_block_valid,
  output block_t tx_block_out,
  output logic   tx_block_out_valid
);

  scr_state_t state_q, state_d, state_nxt;
  block_t     out_q, out_d;
  payload_t   pay;
  logic       vld_q;

  pcs_10g_scr_core u_core (
    .state_i (state_q),
    .data_i  (tx_block_in[PAYLOAD_W-1:0]),
    .mode_i  (SCR_MODE_SCRAMBLE),
    .data_o  (pay),
    .state_o (state_nxt)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (tx_block_valid) begin
      state_d = state_nxt;
      out_d   = {tx_block_in[BLOCK_W-1:PAYLOAD_W], pay};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCR_SEED;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= tx_block_valid;
    end
  end

  assign tx_block_out       = out_q;
  assign tx_block_out_valid = vld_q;

endmodule

module pcs_10g_descrambler
  import pcs_10g_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  block_t rx_block_in,
  input  logic   rx_block_valid,
  output block_t rx_block_out,
  output logic   rx_block_out_valid
);

  scr_state_t state_q, state_d, state_nxt;
  block_t     out_q, out_d;
  payload_t   pay;
  logic       vld_q;

  // State follows received bits only, which is what makes the RX side self-synchronizing
  pcs_10g_scr_core u_core (
    .state_i (state_q),
    .data_i  (rx_block_in[PAYLOAD_W-1:0]),
    .mode_i  (SCR_MODE_DESCRAMBLE),
    .data_o  (pay),
    .state_o (state_nxt)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (rx_block_valid) begin
      state_d = state_nxt;
      out_d   = {rx_block_in[BLOCK_W-1:PAYLOAD_W], pay};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCR_SEED;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= rx_block_valid;
    end
  end

  assign rx_block_out       = out_q;
  assign rx_block_out_valid = vld_q;

endmodule

// File: rtl/pcs_10g_scrambler_pair.sv
// rtl/pcs_10g_scrambler_pair.sv - TX scrambler and RX descrambler paths of the 10GBASE-R PCS
module pcs_10g_scrambler_pair
  import pcs_10g_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  pcs_10g_scrambler_pair_if.slave  tx_blk_i,
  pcs_10g_scrambler_pair_if.master tx_blk_o,
  pcs_10g_scrambler_pair_if.slave  rx_blk_i,
  pcs_10g_scrambler_pair_if.master rx_blk_o
);

  pcs_10g_scrambler u_scr (
    .clk                (clk),
    .rst_n              (rst_n),
    .tx_block_in        (tx_blk_i.tdata),
    .tx_block_valid     (tx_blk_i.tvalid),
    .tx_block_out       (tx_blk_o.tdata),
    .tx_block_out_valid (tx_blk_o.tvalid)
  );

  pcs_10g_descrambler u_dscr (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_block_in        (rx_blk_i.tdata),
    .rx_block_valid     (rx_blk_i.tvalid),
    .rx_block_out       (rx_blk_o.tdata),
    .rx_block_out_valid (rx_blk_o.tvalid)
  );

endmodule

// File: tb/tb_pcs_10g_scrambler_pair.sv
// tb/tb_pcs_10g_scrambler_pair.sv - bench for the scrambler pair, TX output looped into RX input
module tb_pcs_10g_scrambler_pair;
  import pcs_10g_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcs_10g_scrambler_pair_if tx_in_if ();
  pcs_10g_scrambler_pair_if tx_out_if ();
  pcs_10g_scrambler_pair_if rx_in_if ();
  pcs_10g_scrambler_pair_if rx_out_if ();

  logic [65:0] err_mask = '0;
  assign rx_in_if.tdata  = tx_out_if.tdata ^ err_mask;
  assign rx_in_if.tvalid = tx_out_if.tvalid;

  pcs_10g_scrambler_pair dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_blk_i (tx_in_if.slave),
    .tx_blk_o (tx_out_if.master),
    .rx_blk_i (rx_in_if.slave),
    .rx_blk_o (rx_out_if.master)
  );

  int errors = 0;
  int checks = 0;

  // Serial-stream reference: the scrambled bit stream as a queue, newest at the back
  bit tx_hist[$];
  bit rx_hist[$];
  logic [65:0] exp_tx, exp_rx;
  logic        exp_tx_v, exp_rx_v;
  logic [65:0] orig_q[$];
  int          excuse;

  typedef struct {
    logic [65:0] blk;
    logic [1:0]  exp_hdr;
    logic [63:0] exp_pay;
    bit          pay_known;
    bit          pay_differs;
  } vec_t;

  vec_t vecs[13];

  function automatic void model_reset();
    tx_hist.delete();
    rx_hist.delete();
    for (int i = 0; i < 58; i++) begin
      tx_hist.push_back(1'b1);
      rx_hist.push_back(1'b1);
    end
    exp_tx   = '0;
    exp_rx   = '0;
    exp_tx_v = 1'b0;
    exp_rx_v = 1'b0;
    orig_q.delete();
    excuse = 0;
  endfunction

  function automatic logic [63:0] ref_scramble(logic [63:0] d);
    logic [63:0] s;
    int n;
    for (int i = 0; i < 64; i++) begin
      n = tx_hist.size();
      s[i] = d[i] ^ tx_hist[n-39] ^ tx_hist[n-58];
      tx_hist.push_back(s[i]);
    end
    while (tx_hist.size() > 58) void'(tx_hist.pop_front());
    return s;
  endfunction

  function automatic logic [63:0] ref_descramble(logic [63:0] s);
    logic [63:0] d;
    int n;
    for (int i = 0; i < 64; i++) begin
      n = rx_hist.size();
      d[i] = s[i] ^ rx_hist[n-39] ^ rx_hist[n-58];
      rx_hist.push_back(s[i]);
    end
    while (rx_hist.size() > 58) void'(rx_hist.pop_front());
    return d;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: check outputs of the previous edge, drive this cycle's input, advance the model
  task automatic step(input logic v, input logic [65:0] blk, input logic [65:0] mask);
    logic [65:0] o;
    @(negedge clk);
    check("tx_valid", {65'd0, tx_out_if.tvalid}, {65'd0, exp_tx_v});
    check("tx_data", tx_out_if.tdata, exp_tx);
    check("rx_valid", {65'd0, rx_out_if.tvalid}, {65'd0, exp_rx_v});
    check("rx_data", rx_out_if.tdata, exp_rx);
    if (rx_out_if.tvalid === 1'b1) begin
      if (orig_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rt_extra: rx valid with no block outstanding, got %h", rx_out_if.tdata);
      end else begin
        o = orig_q.pop_front();
        if (excuse > 0) excuse--;
        else check("round_trip", rx_out_if.tdata, o);
      end
    end
    tx_in_if.tdata  = blk;
    tx_in_if.tvalid = v;
    err_mask        = mask;
    if (exp_tx_v) begin
      exp_rx = {exp_tx[65:64] ^ mask[65:64], ref_descramble(exp_tx[63:0] ^ mask[63:0])};
      if (mask != '0) excuse = 2;
    end
    exp_rx_v = exp_tx_v;
    if (v) begin
      exp_tx = {blk[65:64], ref_scramble(blk[63:0])};
      orig_q.push_back(blk);
    end
    exp_tx_v = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tx_in_if.tvalid = 1'b0;
    tx_in_if.tdata  = '0;
    err_mask = '0;
    #1;
    check("rst_tx_data", tx_out_if.tdata, '0);
    check("rst_tx_valid", {65'd0, tx_out_if.tvalid}, '0);
    check("rst_rx_data", rx_out_if.tdata, '0);
    check("rst_rx_valid", {65'd0, rx_out_if.tvalid}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [65:0] rnd_blk();
    logic [65:0] b;
    b[63:32] = $urandom;
    b[31:0]  = $urandom;
    b[65:64] = ($urandom_range(0, 1) == 0) ? SYNC_DATA : SYNC_CTRL;
    return b;
  endfunction

  initial begin
    logic [31:0] jj;
    logic [65:0] m;

    vecs[0]  = '{{SYNC_DATA, 64'h0},                  SYNC_DATA, 64'h03FF_FF80_0000_0000, 1, 0};
    vecs[1]  = '{{SYNC_DATA, 64'hAAAA_AAAA_AAAA_AAAA}, SYNC_DATA, 64'h0, 0, 1};
    vecs[2]  = '{{SYNC_CTRL, 64'h1E00_0000_0000_0000}, SYNC_CTRL, 64'h0, 0, 0};
    vecs[3]  = '{{SYNC_DATA, 64'hDEAD_BEEF_CAFE_BABE}, SYNC_DATA, 64'h0, 0, 0};
    vecs[4]  = '{{SYNC_DATA, 64'h0123_4567_89AB_CDEF}, SYNC_DATA, 64'h0, 0, 0};
    vecs[5]  = '{{SYNC_CTRL, 64'h1E00_0000_0000_0000}, SYNC_CTRL, 64'h0, 0, 0};
    vecs[6]  = '{{SYNC_DATA, 64'h5555_5555_5555_5555}, SYNC_DATA, 64'h0, 0, 1};
    vecs[7]  = '{{SYNC_DATA, 64'hFFFF_FFFF_FFFF_FFFF}, SYNC_DATA, 64'h0, 0, 0};
    vecs[8]  = '{{SYNC_DATA, 64'h0},                  SYNC_DATA, 64'h0, 0, 0};
    vecs[9]  = '{{SYNC_CTRL, 64'h3300_1122_3344_5566}, SYNC_CTRL, 64'h0, 0, 0};
    vecs[10] = '{{SYNC_DATA, 64'hFEDC_BA98_7654_3210}, SYNC_DATA, 64'h0, 0, 0};
    vecs[11] = '{{SYNC_CTRL, 64'h8707_0707_0707_0707}, SYNC_CTRL, 64'h0, 0, 0};
    vecs[12] = '{{SYNC_DATA, 64'hAAAA_AAAA_AAAA_AAAA}, SYNC_DATA, 64'h0, 0, 1};

    tx_in_if.tdata  = '0;
    tx_in_if.tvalid = 1'b0;
    model_reset();
    do_reset();

    // Table vectors back-to-back straight out of reset; tx_out lags the table by one step
    for (int k = 0; k <= 13; k++) begin
      if (k < 13) step(1'b1, vecs[k].blk, '0);
      else        step(1'b0, '0, '0);
      if (k > 0) begin
        check("vec_hdr", {64'd0, tx_out_if.tdata[65:64]}, {64'd0, vecs[k-1].exp_hdr});
        if (vecs[k-1].pay_known)
          check("vec_pay", {2'b00, tx_out_if.tdata[63:0]}, {2'b00, vecs[k-1].exp_pay});
        if (vecs[k-1].pay_differs) begin
          checks++;
          if (tx_out_if.tdata[63:0] === vecs[k-1].blk[63:0]) begin
            errors++;
            $display("FAIL vec_scrambled: payload %h left unscrambled", tx_out_if.tdata[63:0]);
          end
        end
      end
    end
    repeat (2) step(1'b0, '0, '0);

    for (int j = 0; j < 200; j++) begin
      jj = j;
      step(1'b1, {SYNC_DATA, jj, ~jj}, '0);
    end
    repeat (2) step(1'b0, '0, '0);

    // Gapped traffic; idle-cycle data is junk that must not disturb anything
    for (int p = 0; p < 30; p++) begin
      step(1'b1, rnd_blk(), '0);
      repeat ($urandom_range(1, 5)) step(1'b0, rnd_blk(), '0);
    end
    repeat (2) step(1'b0, '0, '0);

    // Line error into the descrambler: two blocks may be lost, then recovery
    for (int p = 0; p < 12; p++) begin
      m = '0;
      if (p == 4) begin
        m[63:32] = $urandom;
        m[31:0]  = $urandom | 32'h8000_0001;
      end
      step(1'b1, rnd_blk(), m);
    end
    repeat (2) step(1'b0, '0, '0);

    // Reset mid-stream, then the first block must again start from the seed
    for (int p = 0; p < 5; p++) step(1'b1, rnd_blk(), '0);
    do_reset();
    step(1'b1, {SYNC_DATA, 64'h0}, '0);
    step(1'b0, '0, '0);
    check("reseed", tx_out_if.tdata, {SYNC_DATA, 64'h03FF_FF80_0000_0000});
    for (int p = 0; p < 20; p++) step(1'b1, rnd_blk(), '0);
    repeat (3) step(1'b0, '0, '0);

    checks++;
    if (orig_q.size() != 0) begin
      errors++;
      $display("FAIL rt_missing: %0d blocks never came back, expected 0", orig_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
